frame_readout_sched: RTL and testbench

FRAME_READOUT_SCHED -- requirements
Module: frame_readout_sched

---
 rtl/frame_sched_pkg.sv | 47 ++++
 rtl/hyst_flag.sv | 24 ++
 rtl/frame_readout_sched.sv | 164 ++++++++++++++++
 tb/tb_frame_readout_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame readout scheduler: FSM state encoding,
// statistics counter width and the elaboration-time watermark helpers.
package frame_sched_pkg;

  // Scheduler states; encodings are fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int unsigned STAT_W = 16;

  // Throttle asserts this close below the full UPPER_BOUND-frame level.
  function automatic logic [31:0] throttle_set_level(input int unsigned frame_size,
                                                     input int unsigned upper_bound,
                                                     input int unsigned pre_trig);
    return frame_size * upper_bound - pre_trig;
  endfunction

  // Throttle releases once roughly one frame has been drained below the set level.
  function automatic logic [31:0] throttle_clr_level(input int unsigned frame_size,
                                                     input int unsigned upper_bound,
                                                     input int unsigned pre_trig);
    return frame_size * (upper_bound - 1) + pre_trig;
  endfunction

  // Starve asserts just above the LOWER_BOUND-frame level.
  function automatic logic [31:0] starve_set_level(input int unsigned frame_size,
                                                   input int unsigned lower_bound,
                                                   input int unsigned pre_trig);
    return frame_size * lower_bound + pre_trig;
  endfunction

  // Starve releases once roughly one more frame has accumulated.
  function automatic logic [31:0] starve_clr_level(input int unsigned frame_size,
                                                   input int unsigned lower_bound,
                                                   input int unsigned pre_trig);
    return frame_size * (lower_bound + 1) - pre_trig;
  endfunction

  // Word counter width: ceil(log2(frame_size)), never narrower than one bit.
  function automatic int unsigned word_cnt_width(input int unsigned frame_size);
    return (frame_size > 1) ? $clog2(frame_size) : 1;
  endfunction

endpackage

// File: rtl/hyst_flag.sv
// Registered flag with hysteresis: set and clear conditions come from
// separate watermarks so the flag does not chatter around one threshold.
module hyst_flag (
  input  logic clk,
  input  logic reset,
  input  logic set_cond,
  input  logic clr_cond,
  output logic flag
);

  // Set wins over clear; the watermark checks in the parent keep them disjoint.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every flop, so all registers sample
    // pre-edge values regardless of the order blocks are evaluated in.
    if (reset) begin
      flag <= 1'b0;
    end else if (set_cond) begin
      flag <= 1'b1;
    end else if (clr_cond) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_readout_sched.sv
// Frame readout scheduler: drains whole frames from a FIFO to a sink, one
// FRAME_SIZE-word burst at a time with a fixed inter-frame gap, and raises
// hysteretic throttle/starve flags from the FIFO fill level.
//
// Optional feature: define FRAME_SCHED_STATS_EN to build the saturating
// frames_sent_o / throttle_hits_o counters. Without it both ports read 0 and
// no counter logic exists.
module frame_readout_sched
  import frame_sched_pkg::*;
#(
  parameter int unsigned FRAME_SIZE  = 1280,
  parameter int unsigned UPPER_BOUND = 10,
  parameter int unsigned LOWER_BOUND = 2,
  parameter int unsigned PRE_TRIG    = 1,
  parameter int unsigned COUNT_W     = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_wr_en_i,
  input  logic [COUNT_W-1:0] fifo_rd_data_count_i,
  input  logic               sink_ready_i,
  output logic               fifo_rd_en_o,
  output logic               frame_start_o,
  output logic               frame_end_o,
  output logic               wr_throttle_o,
  output logic               starve_o,
  output logic               busy_o,
  output logic [STAT_W-1:0]  frames_sent_o,
  output logic [STAT_W-1:0]  throttle_hits_o
);

  localparam int unsigned WCNT_W = word_cnt_width(FRAME_SIZE);

  // Watermarks are fixed at elaboration in 32-bit arithmetic.
  localparam logic [31:0] FRAME_WORDS = 32'(FRAME_SIZE);
  localparam logic [31:0] THR_SET = throttle_set_level(FRAME_SIZE, UPPER_BOUND, PRE_TRIG);
  localparam logic [31:0] THR_CLR = throttle_clr_level(FRAME_SIZE, UPPER_BOUND, PRE_TRIG);
  localparam logic [31:0] STV_SET = starve_set_level(FRAME_SIZE, LOWER_BOUND, PRE_TRIG);
  localparam logic [31:0] STV_CLR = starve_clr_level(FRAME_SIZE, LOWER_BOUND, PRE_TRIG);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_SIZE - 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;

  // Reject configurations whose watermarks cannot be represented or overlap.
  if (COUNT_W < 1 || COUNT_W > 32) begin : g_bad_count_w
    $error("frame_readout_sched: COUNT_W must be in 1..32");
  end
  if (64'(FRAME_SIZE) * 64'(UPPER_BOUND) >= (64'd1 << COUNT_W)) begin : g_bad_upper
    $error("frame_readout_sched: FRAME_SIZE*UPPER_BOUND must be below 2**COUNT_W");
  end
  if (LOWER_BOUND + 1 >= UPPER_BOUND) begin : g_bad_bounds
    $error("frame_readout_sched: LOWER_BOUND+1 must be below UPPER_BOUND");
  end

  sched_state_t      state;
  logic [WCNT_W-1:0] word_cnt;
  logic [31:0]       count_ext;
  logic              count_nonzero;
  logic              frame_avail;
  logic              last_word;
  logic              thr_set_cond;
  logic              thr_clr_cond;
  logic              stv_set_cond;
  logic              stv_clr_cond;

  // The scheduler only looks at the sampled count; concurrent writes merely
  // show up in a later count value and never change the burst sequencing.
  assign count_ext     = 32'(fifo_rd_data_count_i);
  assign count_nonzero = (fifo_rd_data_count_i != '0);
  assign frame_avail   = (count_ext >= FRAME_WORDS);
  assign last_word     = (word_cnt == LAST_WORD);

  // Reads are combinational so a sink stall takes effect in the same cycle;
  // an empty FIFO or an active reset suppresses the read.
  assign fifo_rd_en_o  = !reset && (state == BURST) && sink_ready_i && count_nonzero;
  assign frame_start_o = fifo_rd_en_o && (word_cnt == '0);
  assign frame_end_o   = fifo_rd_en_o && last_word;

  // Burst sequencer: IDLE waits for a whole frame, BURST counts reads, GAP
  // inserts the one dead cycle that gives a two-cycle inter-frame spacing.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // is not in the sensitivity list.
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      busy_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_avail && sink_ready_i) begin
            state  <= BURST;
            busy_o <= 1'b1;
          end
        end
        BURST: begin
          if (fifo_rd_en_o) begin
            if (last_word) begin
              word_cnt <= '0;
              state    <= GAP;
              busy_o   <= 1'b0;
            end else begin
              word_cnt <= word_cnt + WCNT_W'(1);
            end
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          word_cnt <= '0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

  assign thr_set_cond = (count_ext >= THR_SET);
  assign thr_clr_cond = (count_ext <= THR_CLR);
  assign stv_set_cond = (count_ext <= STV_SET);
  assign stv_clr_cond = (count_ext >= STV_CLR);

  hyst_flag u_throttle (
    .clk      (clk),
    .reset    (reset),
    .set_cond (thr_set_cond),
    .clr_cond (thr_clr_cond),
    .flag     (wr_throttle_o)
  );

  hyst_flag u_starve (
    .clk      (clk),
    .reset    (reset),
    .set_cond (stv_set_cond),
    .clr_cond (stv_clr_cond),
    .flag     (starve_o)
  );

`ifdef FRAME_SCHED_STATS_EN
  // Saturating statistics: completed frames and writes attempted while throttled.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_sent_o   <= '0;
      throttle_hits_o <= '0;
    end else begin
      if (frame_end_o && (frames_sent_o != STAT_MAX)) begin
        frames_sent_o <= frames_sent_o + STAT_W'(1);
      end
      if (fifo_wr_en_i && wr_throttle_o && (throttle_hits_o != STAT_MAX)) begin
        throttle_hits_o <= throttle_hits_o + STAT_W'(1);
      end
    end
  end
`else
  assign frames_sent_o   = '0;
  assign throttle_hits_o = '0;

  // The write enable only feeds the statistics, so it is intentionally unused here.
  logic unused_wr_en;
  assign unused_wr_en = fifo_wr_en_i;
`endif

endmodule

// File: tb/tb_frame_readout_sched.sv
// Self-checking bench for frame_readout_sched (FRAME_SIZE=4, UPPER_BOUND=3,
// LOWER_BOUND=1, PRE_TRIG=1, COUNT_W=8). A frame-level model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_frame_readout_sched;

  localparam int FS = 4;
  localparam int UB = 3;
  localparam int LB = 1;
  localparam int PT = 1;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_wr_en_i = 1'b0;
  logic [CW-1:0] fifo_rd_data_count_i = '0;
  logic          sink_ready_i = 1'b0;
  logic          fifo_rd_en_o;
  logic          frame_start_o;
  logic          frame_end_o;
  logic          wr_throttle_o;
  logic          starve_o;
  logic          busy_o;
  logic [15:0]   frames_sent_o;
  logic [15:0]   throttle_hits_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Frame-level model state.
  bit m_in_frame = 1'b0;
  int m_words    = 0;
  int m_cool     = 0;
  bit m_thr      = 1'b0;
  bit m_stv      = 1'b0;
  int m_frames   = 0;
  int m_hits     = 0;

  frame_readout_sched #(
    .FRAME_SIZE  (FS),
    .UPPER_BOUND (UB),
    .LOWER_BOUND (LB),
    .PRE_TRIG    (PT),
    .COUNT_W     (CW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .fifo_wr_en_i         (fifo_wr_en_i),
    .fifo_rd_data_count_i (fifo_rd_data_count_i),
    .sink_ready_i         (sink_ready_i),
    .fifo_rd_en_o         (fifo_rd_en_o),
    .frame_start_o        (frame_start_o),
    .frame_end_o          (frame_end_o),
    .wr_throttle_o        (wr_throttle_o),
    .starve_o             (starve_o),
    .busy_o               (busy_o),
    .frames_sent_o        (frames_sent_o),
    .throttle_hits_o      (throttle_hits_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is granted once a whole frame is present and the sink is
  // ready, after a mandatory one-cycle cooldown following the previous frame.
  task automatic model_step();
    int  cnt;
    bit  rd;
    cnt = int'(fifo_rd_data_count_i);
    if (reset) begin
      m_in_frame = 1'b0; m_words = 0; m_cool = 0;
      m_thr = 1'b0; m_stv = 1'b0; m_frames = 0; m_hits = 0;
    end else begin
      rd = m_in_frame && sink_ready_i && (cnt != 0);
      if (fifo_wr_en_i && m_thr && m_hits < 65535) m_hits++;
      if (rd) begin
        m_words++;
        if (m_words == FS) begin
          m_words = 0;
          m_in_frame = 1'b0;
          m_cool = 1;
          if (m_frames < 65535) m_frames++;
        end
      end else if (!m_in_frame) begin
        if (m_cool > 0) m_cool--;
        else if (cnt >= FS && sink_ready_i) m_in_frame = 1'b1;
      end
      if (cnt >= FS * UB - PT) m_thr = 1'b1;
      else if (cnt <= FS * (UB - 1) + PT) m_thr = 1'b0;
      if (cnt <= FS * LB + PT) m_stv = 1'b1;
      else if (cnt >= FS * (LB + 1) - PT) m_stv = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic exp_rd;
    int   exp_frames;
    int   exp_hits;
    @(negedge clk);
    if (mon_en) begin
      exp_rd = !reset && m_in_frame && sink_ready_i && (fifo_rd_data_count_i != '0);
`ifdef FRAME_SCHED_STATS_EN
      exp_frames = m_frames;
      exp_hits   = m_hits;
`else
      exp_frames = 0;
      exp_hits   = 0;
`endif
      check_bit("mon_rd_en", fifo_rd_en_o, exp_rd);
      check_bit("mon_frame_start", frame_start_o, exp_rd && (m_words == 0));
      check_bit("mon_frame_end", frame_end_o, exp_rd && (m_words == FS - 1));
      check_bit("mon_busy", busy_o, m_in_frame);
      check_bit("mon_throttle", wr_throttle_o, m_thr);
      check_bit("mon_starve", starve_o, m_stv);
      check_val("mon_frames_sent", int'(frames_sent_o), exp_frames);
      check_val("mon_throttle_hits", int'(throttle_hits_o), exp_hits);
    end
  end

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic drive(input int cnt, input logic sink, input logic wr, input logic rst);
    @(posedge clk);
    #1;
    fifo_rd_data_count_i = CW'(cnt);
    sink_ready_i = sink;
    fifo_wr_en_i = wr;
    reset = rst;
    @(negedge clk);
  endtask

  // One frame from IDLE with count=FS; count drops to 0 once the end is seen.
  task automatic run_frame(input logic [15:0] sink_mask, output logic [7:0] rd_vec,
                           output logic [7:0] st_vec, output logic [7:0] en_vec,
                           output int reads, output int ends);
    bit done = 1'b0;
    int post = 0;
    rd_vec = '0; st_vec = '0; en_vec = '0; reads = 0; ends = 0;
    for (int i = 0; i < 40; i++) begin
      drive(done ? 0 : FS, (i < 16) ? sink_mask[i] : 1'b1, 1'b0, 1'b0);
      if (i < 8) begin
        rd_vec[i] = fifo_rd_en_o;
        st_vec[i] = frame_start_o;
        en_vec[i] = frame_end_o;
      end
      reads += int'(fifo_rd_en_o);
      ends  += int'(frame_end_o);
      if (frame_end_o) done = 1'b1;
      if (done) post++;
      if (post > 3 && i >= 7) break;
    end
    check_bit("frame_completed", done, 1'b1);
  endtask

  initial begin
    logic [7:0] rd_vec, st_vec, en_vec;
    int reads, ends, ends_seen;
    int end_idx[3];
    int thr_cnt[5] = '{9, 11, 10, 9, 8};
    int thr_exp[5] = '{0, 0, 1, 1, 0};
    int stv_cnt[5] = '{6, 5, 6, 7, 7};
    int stv_exp[5] = '{0, 0, 1, 1, 0};
    bit seen;

    // Reset with count 0.
    drive(0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0);
    check_bit("reset_busy", busy_o, 1'b0);
    check_bit("reset_rd_en", fifo_rd_en_o, 1'b0);
    check_bit("reset_throttle", wr_throttle_o, 1'b0);
    check_bit("reset_starve", starve_o, 1'b0);
    check_val("reset_frames", int'(frames_sent_o), 0);
    drive(0, 1'b0, 1'b0, 1'b0);
    check_bit("starve_after_empty", starve_o, 1'b1);

    // Plain frame: grant cycle, four reads, then quiet.
    run_frame(16'hFFFF, rd_vec, st_vec, en_vec, reads, ends);
    check_val("plain_rd_pattern", int'(rd_vec), 8'b0001_1110);
    check_val("plain_start_pattern", int'(st_vec), 8'b0000_0010);
    check_val("plain_end_pattern", int'(en_vec), 8'b0001_0000);
    check_val("plain_reads", reads, 4);

    // Sink stalls on burst cycles 2-3.
    run_frame(16'hFFF3, rd_vec, st_vec, en_vec, reads, ends);
    check_val("stall_rd_pattern", int'(rd_vec), 8'b0111_0010);
    check_val("stall_reads", reads, 4);
    check_val("stall_ends", ends, 1);

    // Throttle hysteresis, sink held off so no burst starts.
    for (int i = 0; i < 5; i++) begin
      drive(thr_cnt[i], 1'b0, 1'b0, 1'b0);
      check_bit($sformatf("throttle_step%0d", i), wr_throttle_o, thr_exp[i][0]);
    end

    // Starve hysteresis.
    for (int i = 0; i < 5; i++) begin
      drive(stv_cnt[i], 1'b0, 1'b0, 1'b0);
      check_bit($sformatf("starve_step%0d", i), starve_o, stv_exp[i][0]);
    end
    drive(0, 1'b0, 1'b0, 1'b0);

    // Reset after two reads abandons the frame; the next one starts clean.
    drive(FS, 1'b1, 1'b0, 1'b0);
    drive(FS, 1'b1, 1'b0, 1'b0);
    check_bit("rst_first_start", frame_start_o, 1'b1);
    drive(FS, 1'b1, 1'b0, 1'b0);
    check_bit("rst_second_read", fifo_rd_en_o, 1'b1);
    drive(FS, 1'b1, 1'b0, 1'b1);
    drive(FS, 1'b1, 1'b0, 1'b0);
    check_bit("rst_after_rd_en", fifo_rd_en_o, 1'b0);
    check_bit("rst_after_busy", busy_o, 1'b0);
    check_bit("rst_after_end", frame_end_o, 1'b0);
    check_bit("rst_after_starve", starve_o, 1'b0);
    check_bit("rst_after_throttle", wr_throttle_o, 1'b0);
    drive(FS, 1'b1, 1'b0, 1'b0);
    check_bit("rst_restart_rd", fifo_rd_en_o, 1'b1);
    check_bit("rst_restart_start", frame_start_o, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      drive(FS, 1'b1, 1'b0, 1'b0);
      if (frame_end_o) begin
        seen = 1'b1;
        check_val("rst_restart_end_cycle", i, 2);
      end
    end
    check_bit("rst_restart_end_seen", seen, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);

    // Statistics: three back-to-back frames, then five throttled writes.
    drive(0, 1'b0, 1'b0, 1'b1);
    ends_seen = 0;
    end_idx = '{-1, -1, -1};
    for (int i = 0; i < 40 && ends_seen < 3; i++) begin
      drive(FS, 1'b1, 1'b0, 1'b0);
      if (frame_end_o) begin
        end_idx[ends_seen] = i;
        ends_seen++;
      end
    end
    check_val("stats_end0_cycle", end_idx[0], 4);
    check_val("stats_end1_cycle", end_idx[1], 10);
    check_val("stats_end2_cycle", end_idx[2], 16);
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(FS * UB - PT, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(FS * UB - PT, 1'b0, 1'b1, 1'b0);
    drive(FS * UB - PT, 1'b0, 1'b0, 1'b0);
`ifdef FRAME_SCHED_STATS_EN
    check_val("stats_frames_sent", int'(frames_sent_o), 3);
    check_val("stats_throttle_hits", int'(throttle_hits_o), 5);
`else
    check_val("stats_frames_sent", int'(frames_sent_o), 0);
    check_val("stats_throttle_hits", int'(throttle_hits_o), 0);
`endif
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
